decode_issue_sequencer: RTL and testbench
=========================================

# decode_issue_sequencer

Issue controller sitting between instruction fetch and the `decoder` block. It accepts instructions over a valid/ready handshake and holds each one in a single-entry buffer. A per-register scoreboard blocks read-after-write and write-after-write hazards until writeback retires the destination. The block drives the decoder's `instr`/`enable` pair one instruction per pulse and halts the front end on EBREAK until software resumes it.

## Interface
- `ILEN`, 32: instruction width.
- `NREGS`, 32: architectural registers; register index width is `$clog2(NREGS)` (5).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-low (the block resets when `rst==0` at a rising edge of `clk`).
- `fetch_valid`  in  1  fetch presents an instruction.
- `fetch_instr`  in  ILEN  instruction word.
- `fetch_ready`  out  1  sequencer accepts the word this cycle.
- `dec_instr`  out  ILEN  instruction to decoder `instr`.
- `dec_enable`  out  1  one-cycle issue pulse to decoder `enable`.
- `wb_valid`  in  1  writeback retires a register this cycle.
- `wb_rd`  in  5  register retired.
- `resume`  in  1  leave HALT.
- `halted`  out  1  high while in HALT.
- `busy_mask`  out  NREGS  scoreboard; bit r set means a write to r is pending.
- `stall_cnt`  out  16  saturating count of hazard-stall cycles.

## Operation
- Fields are taken at RV32 positions: rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0].
- rs1 and rs2 are always treated as sources, which is conservative.
- rd is a destination unless the opcode is 7'b0100011 (STORE) or 7'b1100011 (BRANCH), or rd==0.
- Hold buffer (`hold_valid`, `hold_instr`):
  - A fetch handshake (`fetch_valid && fetch_ready`) loads the buffer.
  - An issue empties it.
- Hazard: `hold_valid` and any of `busy_mask[rs1]`, `busy_mask[rs2]`, or `busy_mask[rd]` (for a destination) is set. Bit 0 is never set.
- States:
  - RUN: if `hold_valid` and hold is EBREAK (32'h00100073), go to DRAIN. Otherwise, if there is no hazard, issue.
  - DRAIN: `fetch_ready=0`. When `busy_mask==0`, issue EBREAK and go to HALT.
  - HALT: `fetch_ready=0`, `halted=1`. `resume` returns to RUN.
- Issue: register `dec_instr<=hold_instr` and `dec_enable<=1`, set `busy_mask[rd]` for a destination, and clear `hold_valid`. `dec_enable` is 0 on every other cycle. `dec_instr` keeps its last value.
- `fetch_ready = (state==RUN) && (!hold_valid || issue_now)`. `issue_now` is computed from registered state only and never from `fetch_valid` or `wb_*`.
- Writeback: `wb_valid` clears `busy_mask[wb_rd]` at the edge. If it is the same register being set by an issue in the same cycle, set wins. `wb_rd==0` is ignored.
- `stall_cnt` increments in every RUN cycle with `hold_valid && hazard`. It saturates at 16'hFFFF and is cleared only by reset.
- Reset: state RUN, hold empty, `busy_mask=0`, `dec_instr=0`, `dec_enable=0`, `halted=0`, `stall_cnt=0`. A held instruction is dropped. If reset lands in the middle of an operation, `dec_enable` is 0 after that edge.

## Timing
- Handshake at edge N loads hold. The earliest `dec_enable` is high during cycle N+1, so latency from accept to decoder is 1 cycle.
- Back-to-back independent instructions issue every cycle, because `fetch_ready` stays high while issuing.
- Hazard release: a `wb_valid` edge at M clears the bit; the stalled instruction issues at edge M+1 at the earliest.
- `resume` sampled at edge H: state is RUN after H and `fetch_ready` can be 1 in the cycle after H.
- `resume` outside HALT is ignored.
- Simultaneous `wb_valid` and `resume` are both honoured.

## Configuration
- `DECODE_SEQ_SCOREBOARD_EN` defined: scoreboard and hazard stall active, as described above.
- Not defined:
  - The hazard term is constantly 0, `busy_mask` is tied to 0, and `stall_cnt` stays 0.
  - DRAIN exits on its first cycle.
  - Software is responsible for spacing dependent instructions.

## Test plan
- Reset → `fetch_ready=1`, `dec_enable=0`, `busy_mask=0`, `stall_cnt=0`, `halted=0`.
- Issue 0x00500093 (addi x1,x0,5) → `dec_enable` pulses 1 cycle after accept, `dec_instr=0x00500093`, `busy_mask=32'h2`.
- Then 0x00108133 (add x2,x1,x1) with no writeback for 3 cycles → no issue and `stall_cnt=3`. Next, `wb_valid=1, wb_rd=1` → issue on the following edge and `busy_mask=32'h4`.
- 0x00102023 (sw x1,0(x0)) with x1 not busy → issues and `busy_mask` is unchanged.
- Same-cycle issue to x3 and `wb_rd=3` → bit 3 set afterwards.
- EBREAK with `busy_mask=32'h4` → DRAIN with `fetch_ready=0`. `wb_rd=2` → EBREAK issued, then `halted=1`. `resume` → RUN. Reset asserted in DRAIN → RUN with hold empty.

Source files
------------

// File: rtl/decode_issue_sequencer_if.sv
// Fetch/decode/writeback bundle for decode_issue_sequencer.
// master = environment (fetch, writeback, resume); slave = the sequencer.
interface decode_issue_sequencer_if #(
  parameter int ILEN  = 32,
  parameter int NREGS = 32
);
  localparam int RW = $clog2(NREGS);

  logic             fetch_valid;
  logic [ILEN-1:0]  fetch_instr;
  logic             fetch_ready;
  logic [ILEN-1:0]  dec_instr;
  logic             dec_enable;
  logic             wb_valid;
  logic [RW-1:0]    wb_rd;
  logic             resume;
  logic             halted;
  logic [NREGS-1:0] busy_mask;
  logic [15:0]      stall_cnt;

  modport master (
    output fetch_valid, fetch_instr, wb_valid, wb_rd, resume,
    input  fetch_ready, dec_instr, dec_enable, halted, busy_mask, stall_cnt
  );

  modport slave (
    input  fetch_valid, fetch_instr, wb_valid, wb_rd, resume,
    output fetch_ready, dec_instr, dec_enable, halted, busy_mask, stall_cnt
  );
endinterface

// File: rtl/decode_issue_sequencer.sv
// Issue sequencer: one-entry hold buffer feeding the decoder, RAW/WAW scoreboard, EBREAK drain/halt.
// Scoreboard only when DECODE_SEQ_SCOREBOARD_EN is defined; otherwise dependent spacing is software's job.
module decode_issue_sequencer #(
  parameter int ILEN  = 32,
  parameter int NREGS = 32
) (
  input  logic clk,
  input  logic rst,
  decode_issue_sequencer_if.slave bus
);
  localparam logic [ILEN-1:0] EBREAK = ILEN'(32'h00100073);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  state_e           state_q, state_d;
  logic             hold_valid_q, hold_valid_d;
  logic [ILEN-1:0]  hold_instr_q, hold_instr_d;
  logic [ILEN-1:0]  dec_instr_q, dec_instr_d;
  logic             dec_enable_q, dec_enable_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [NREGS-1:0] busy_mask;
  logic             hazard;
  logic             issue_now;
  logic             fetch_ready;
  logic             is_ebreak;

  assign is_ebreak = (hold_instr_q == EBREAK);

`ifdef DECODE_SEQ_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;
  logic [4:0]       rd, rs1, rs2;
  logic [6:0]       opcode;
  logic             is_dest;

  assign rd     = hold_instr_q[11:7];
  assign rs1    = hold_instr_q[19:15];
  assign rs2    = hold_instr_q[24:20];
  assign opcode = hold_instr_q[6:0];
  // Stores and branches carry an immediate in the rd slot, not a destination.
  assign is_dest = (rd != 5'd0) && (opcode != 7'b0100011) && (opcode != 7'b1100011);
  assign hazard  = hold_valid_q &&
                   (busy_q[rs1] || busy_q[rs2] || (is_dest && busy_q[rd]));
  assign busy_mask = busy_q;

  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid && (bus.wb_rd != '0)) busy_d[bus.wb_rd] = 1'b0;
    // Applied after the writeback clear so a same-cycle issue to the same register wins.
    if (issue_now && is_dest) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_valid, bus.wb_rd};
  assign hazard    = 1'b0;
  assign busy_mask = '0;
`endif

  always_comb begin
    state_d   = state_q;
    issue_now = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hold_valid_q && is_ebreak)    state_d = DRAIN;
        else if (hold_valid_q && !hazard) issue_now = 1'b1;
      end
      DRAIN: begin
        if (busy_mask == '0) begin
          issue_now = 1'b1;
          state_d   = HALT;
        end
      end
      HALT: begin
        if (bus.resume) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // issue_now depends only on registered state, so ready never combinationally loops to valid.
  assign fetch_ready = (state_q == RUN) && (!hold_valid_q || issue_now);

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    if (issue_now) hold_valid_d = 1'b0;
    if (bus.fetch_valid && fetch_ready) begin
      hold_valid_d = 1'b1;
      hold_instr_d = bus.fetch_instr;
    end
    dec_enable_d = issue_now;
    dec_instr_d  = issue_now ? hold_instr_q : dec_instr_q;
    stall_cnt_d  = stall_cnt_q;
    if ((state_q == RUN) && hazard && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      dec_instr_q  <= '0;
      dec_enable_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      dec_instr_q  <= dec_instr_d;
      dec_enable_q <= dec_enable_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.dec_instr   = dec_instr_q;
  assign bus.dec_enable  = dec_enable_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.busy_mask   = busy_mask;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_decode_issue_sequencer.sv
// Bench for decode_issue_sequencer: directed table, multi-cycle corner sequences, random vs. reference model.
module tb_decode_issue_sequencer;
`ifdef DECODE_SEQ_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  localparam logic [31:0] EBRK = 32'h00100073;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_issue_sequencer_if #(.ILEN(32), .NREGS(32)) bus ();
  decode_issue_sequencer #(.ILEN(32), .NREGS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pending-write set, hold queue, mode and counters.
  int          m_mode;
  logic [31:0] m_hold[$];
  bit          m_pend[32];
  int          m_stall;
  logic [31:0] m_dinstr;
  bit          m_en;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) if (m_pend[i]) v = v | (32'd1 << i);
    return v;
  endfunction

  function automatic bit m_writes_reg(logic [31:0] ins);
    int op = int'(ins % 128);
    int rd = int'((ins >> 7) % 32);
    return (rd != 0) && (op != 'h23) && (op != 'h63);
  endfunction

  task automatic drive(input bit fv, input logic [31:0] fi, input bit wbv,
                       input logic [4:0] wbrd, input bit res);
    bus.fetch_valid = fv;
    bus.fetch_instr = fi;
    bus.wb_valid    = wbv;
    bus.wb_rd       = wbrd;
    bus.resume      = res;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    // A valid fetch during reset must be dropped.
    drive(1'b1, 32'h00500093, 1'b1, 5'd1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
    m_mode = M_RUN;
    m_hold.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_stall  = 0;
    m_dinstr = '0;
    m_en     = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    #1;
    chk({tag, "_fetch_ready"}, bus.fetch_ready, 1);
    chk({tag, "_dec_enable"},  bus.dec_enable, 0);
    chk({tag, "_busy"},        bus.busy_mask, 0);
    chk({tag, "_stall"},       bus.stall_cnt, 0);
    chk({tag, "_halted"},      bus.halted, 0);
  endtask

  // One clock with model prediction; called #1 after a rising edge.
  task automatic cyc(input bit fv, input logic [31:0] fi, input bit wbv,
                     input logic [4:0] wbrd, input bit res);
    logic [31:0] h;
    int rd, rs1, rs2;
    bit full, hz, ebk, iss, any, fr, dst;
    drive(fv, fi, wbv, wbrd, res);
    #1;
    full = (m_hold.size() != 0);
    h    = full ? m_hold[0] : 32'h0;
    rd   = int'((h >> 7) % 32);
    rs1  = int'((h >> 15) % 32);
    rs2  = int'((h >> 20) % 32);
    dst  = m_writes_reg(h);
    hz   = SB && full && (m_pend[rs1] || m_pend[rs2] || (dst && m_pend[rd]));
    any  = 1'b0;
    foreach (m_pend[i]) any |= m_pend[i];
    ebk  = full && (h == EBRK);
    iss  = ((m_mode == M_RUN) && full && !ebk && !hz) || ((m_mode == M_DRAIN) && !any);
    fr   = (m_mode == M_RUN) && (!full || iss);
    chk("fetch_ready", bus.fetch_ready, fr);

    if ((m_mode == M_RUN) && hz && (m_stall < 65535)) m_stall++;
    if (wbv && (wbrd != 0)) m_pend[wbrd] = 1'b0;
    if (iss && dst && SB) m_pend[rd] = 1'b1;
    m_en = iss;
    if (iss) begin
      m_dinstr = h;
      void'(m_hold.pop_front());
    end
    case (m_mode)
      M_RUN:   if (ebk) m_mode = M_DRAIN;
      M_DRAIN: if (iss) m_mode = M_HALT;
      default: if (res) m_mode = M_RUN;
    endcase
    if (fv && fr) m_hold.push_back(fi);

    @(posedge clk); #1;
    chk("dec_enable", bus.dec_enable, m_en);
    chk("dec_instr",  bus.dec_instr, m_dinstr);
    chk("busy_mask",  bus.busy_mask, m_busy());
    chk("halted",     bus.halted, (m_mode == M_HALT));
    chk("stall_cnt",  bus.stall_cnt, m_stall);
  endtask

  typedef struct {
    bit          fv;
    logic [31:0] fi;
    bit          wbv;
    logic [4:0]  wbrd;
    bit          res;
    bit          x_fr;
    bit          x_en;
    logic [31:0] x_di;
    logic [31:0] x_busy;
    bit          x_halt;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [31:0] rand_instr();
    int k = $urandom_range(0, 39);
    logic [31:0] op;
    if (k == 0) return EBRK;
    case (k % 4)
      0: op = 32'h13;
      1: op = 32'h33;
      2: op = 32'h23;
      default: op = 32'h63;
    endcase
    return (32'($urandom_range(0, 5)) << 20) | (32'($urandom_range(0, 5)) << 15) |
           (32'($urandom_range(0, 5)) << 7) | op;
  endfunction

  initial begin
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
    //            fv  instr         wbv wb  res  fr en dec_instr     busy(scoreboard) halted
    tbl[0]  = '{1, 32'h00500093, 0, 0, 0, 1, 0, 32'h00000000, 32'h00, 0};
    tbl[1]  = '{0, 32'h00000000, 0, 0, 0, 1, 1, 32'h00500093, 32'h02, 0};
    tbl[2]  = '{1, 32'h00102023, 1, 1, 0, 1, 0, 32'h00500093, 32'h00, 0};
    tbl[3]  = '{0, 32'h00000000, 0, 0, 0, 1, 1, 32'h00102023, 32'h00, 0};
    tbl[4]  = '{1, 32'h00300193, 0, 0, 0, 1, 0, 32'h00102023, 32'h00, 0};
    tbl[5]  = '{0, 32'h00000000, 1, 3, 0, 1, 1, 32'h00300193, 32'h08, 0};
    tbl[6]  = '{1, 32'h00500093, 1, 3, 0, 1, 0, 32'h00300193, 32'h00, 0};
    tbl[7]  = '{1, 32'h00600213, 0, 0, 0, 1, 1, 32'h00500093, 32'h02, 0};
    tbl[8]  = '{0, 32'h00000000, 1, 1, 0, 1, 1, 32'h00600213, 32'h10, 0};
    tbl[9]  = '{0, 32'h00000000, 1, 4, 0, 1, 0, 32'h00600213, 32'h00, 0};
    tbl[10] = '{0, 32'h00000000, 1, 0, 0, 1, 0, 32'h00600213, 32'h00, 0};
    tbl[11] = '{1, EBRK,         0, 0, 1, 1, 0, 32'h00600213, 32'h00, 0};
    tbl[12] = '{1, 32'h00500093, 0, 0, 0, 0, 0, 32'h00600213, 32'h00, 0};
    tbl[13] = '{1, 32'h00500093, 0, 0, 0, 0, 1, EBRK,         32'h00, 1};
    tbl[14] = '{1, 32'h00500093, 0, 0, 0, 0, 0, EBRK,         32'h00, 1};
    tbl[15] = '{0, 32'h00000000, 0, 0, 1, 0, 0, EBRK,         32'h00, 0};
    tbl[16] = '{1, 32'h00500093, 0, 0, 0, 1, 0, EBRK,         32'h00, 0};

    @(posedge clk); #1;
    do_reset();
    chk_reset("reset");
    chk("reset_dec_instr", bus.dec_instr, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].fv, tbl[i].fi, tbl[i].wbv, tbl[i].wbrd, tbl[i].res);
      #1;
      chk($sformatf("tbl%0d_fetch_ready", i), bus.fetch_ready, tbl[i].x_fr);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_dec_enable", i), bus.dec_enable, tbl[i].x_en);
      chk($sformatf("tbl%0d_dec_instr", i),  bus.dec_instr, tbl[i].x_di);
      chk($sformatf("tbl%0d_busy", i),       bus.busy_mask, SB ? tbl[i].x_busy : 32'h0);
      chk($sformatf("tbl%0d_halted", i),     bus.halted, tbl[i].x_halt);
      chk($sformatf("tbl%0d_stall", i),      bus.stall_cnt, 0);
    end

    // RAW stall on x1, released by writeback.
    do_reset();
    cyc(1, 32'h00500093, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0);
    cyc(1, 32'h00108133, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 32'h0, 0, 0, 0);
`ifdef DECODE_SEQ_SCOREBOARD_EN
    chk("raw_stall_cnt", bus.stall_cnt, 3);
    chk("raw_no_issue", bus.dec_enable, 0);
`endif
    cyc(0, 32'h0, 1, 1, 0);
    cyc(0, 32'h0, 0, 0, 0);
`ifdef DECODE_SEQ_SCOREBOARD_EN
    chk("raw_release_en", bus.dec_enable, 1);
    chk("raw_release_busy", bus.busy_mask, 32'h4);
`endif

    // EBREAK drains behind a pending x2 write, halts, then resumes with a writeback.
    cyc(1, EBRK, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0);
    cyc(1, 32'h00500093, 0, 0, 0);
`ifdef DECODE_SEQ_SCOREBOARD_EN
    chk("drain_not_halted", bus.halted, 0);
`endif
    cyc(1, 32'h00500093, 1, 2, 0);
    cyc(0, 32'h0, 0, 0, 0);
    chk("halt_reached", bus.halted, 1);
    chk("halt_dec_instr", bus.dec_instr, EBRK);
    cyc(1, 32'h00500093, 1, 3, 1);
    chk("resume_left_halt", bus.halted, 0);
    cyc(1, 32'h00500293, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0);

    // Reset in DRAIN drops the held EBREAK.
    cyc(1, EBRK, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0);
    do_reset();
    chk_reset("drain_reset");
    cyc(0, 32'h0, 0, 0, 0);
    chk("drain_reset_no_issue", bus.dec_enable, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        chk_reset("rand_reset");
      end else begin
        cyc(($urandom_range(0, 3) != 0), rand_instr(), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom_range(0, 4) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
